// File: rtl/fp_add_prenorm_if.sv
// Operand/result handshake bundle for fp_add_prenorm.
// slave = adder side, master = producer/consumer side.
interface fp_add_prenorm_if #(
   parameter int C_EXP  = 5,
   parameter int C_MANT = 10
);
   localparam int OPW = C_EXP + C_MANT + 1;
   localparam int MPW = C_MANT + 5;
   localparam int EPW = C_EXP + 2;

   logic           in_valid_i;
   logic           in_ready_o;
   logic [OPW-1:0] op_a_i;
   logic [OPW-1:0] op_b_i;
   logic           out_valid_o;
   logic           out_ready_i;
   logic [MPW-1:0] mant_prenorm_o;
   logic [EPW-1:0] exp_prenorm_o;
   logic           sign_o;

   modport slave (
      input  in_valid_i, op_a_i, op_b_i, out_ready_i,
      output in_ready_o, out_valid_o, mant_prenorm_o, exp_prenorm_o, sign_o
   );

   modport master (
      output in_valid_i, op_a_i, op_b_i, out_ready_i,
      input  in_ready_o, out_valid_o, mant_prenorm_o, exp_prenorm_o, sign_o
   );
endinterface

// File: rtl/fp_add_prenorm.sv
// Two-stage FP16 align/add ahead of the combinational normalizer; unrounded output.
// Define FP_ADD_PRENORM_SKID_EN for a 2-entry output skid and a registered in_ready_o.
module fp_add_prenorm #(
   parameter int C_EXP  = 5,
   parameter int C_MANT = 10,
   parameter int C_BIAS = 15
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   fp_add_prenorm_if.slave    bus
);
   localparam int C_MANT_PRENORM = C_MANT + 5;
   localparam int C_EXP_PRENORM  = C_EXP + 2;
   localparam int OPW = C_EXP + C_MANT + 1;
   localparam int MW  = C_MANT_PRENORM;
   localparam int EW  = C_EXP_PRENORM;

   if (C_BIAS != (2 ** (C_EXP - 1)) - 1) begin : g_bias_chk
      $error("fp_add_prenorm: C_BIAS inconsistent with C_EXP");
   end

   typedef struct packed {
      logic [MW-1:0] mant;
      logic [EW-1:0] exp;
      logic          sign;
   } res_t;

   // Denormals share the exponent of the smallest normal, hidden bit cleared.
   function automatic logic [C_EXP-1:0] eff_exp(input logic [OPW-1:0] op);
      return {op[OPW-2:C_MANT+1], op[C_MANT] | ~|op[OPW-2:C_MANT]};
   endfunction

   function automatic logic [MW-1:0] sig_of(input logic [OPW-1:0] op);
      return {1'b0, |op[OPW-2:C_MANT], op[C_MANT-1:0], 3'b000};
   endfunction

   // ---------------- stage 1: order and align ----------------
   logic [C_EXP-1:0]  ea, eb, el, es, d;
   logic [MW-1:0]     sa, sb, sl, ss, s_al;
   logic [2*MW-1:0]   s_ext;
   logic              a_ge, sign_l;

   always_comb begin
      ea     = eff_exp(bus.op_a_i);
      eb     = eff_exp(bus.op_b_i);
      sa     = sig_of(bus.op_a_i);
      sb     = sig_of(bus.op_b_i);
      a_ge   = (ea > eb) || ((ea == eb) && (sa >= sb));
      el     = a_ge ? ea : eb;
      es     = a_ge ? eb : ea;
      sl     = a_ge ? sa : sb;
      ss     = a_ge ? sb : sa;
      sign_l = a_ge ? bus.op_a_i[OPW-1] : bus.op_b_i[OPW-1];
      d      = el - es;
      // Lower half of the extended shift collects the bits that fall off.
      s_ext  = {ss, {MW{1'b0}}} >> d;
      if (int'(d) >= MW)
         s_al = {{(MW-1){1'b0}}, |ss};
      else
         s_al = s_ext[2*MW-1:MW] | {{(MW-1){1'b0}}, |s_ext[MW-1:0]};
   end

   logic [MW-1:0]    s1_l_q, s1_s_q;
   logic [C_EXP-1:0] s1_exp_q;
   logic             s1_sign_q, s1_sub_q;

   // ---------------- stage 2: add / subtract ----------------
   logic [MW-1:0] sum;
   res_t          s2_d, s2_q;

   always_comb begin
      sum       = s1_sub_q ? (s1_l_q - s1_s_q) : (s1_l_q + s1_s_q);
      s2_d.mant = sum;
      s2_d.exp  = EW'(s1_exp_q);
      // Exact cancellation is +0; -0 + -0 keeps the larger operand's sign.
      s2_d.sign = s1_sign_q & ~(s1_sub_q & ~|sum);
   end

   // ---------------- flow control ----------------
   logic [2:1] vld_q, vld_d;
   logic       in_ready, accept, s2_en, s2_go, out_valid;
   res_t       out_r;

`ifdef FP_ADD_PRENORM_SKID_EN
   res_t       skid0_q, skid1_q;
   logic [1:0] cnt_q, cnt_d;
   logic [2:0] items_d;
   logic       in_ready_q, bypass, push, pop, wr_hi;
`endif

   always_comb begin
`ifdef FP_ADD_PRENORM_SKID_EN
      pop     = bus.out_ready_i & (cnt_q != 2'd0);
      bypass  = vld_q[2] & (cnt_q == 2'd0) & bus.out_ready_i;
      push    = vld_q[2] & ~bypass & (cnt_q != 2'd2);
      wr_hi   = cnt_q[0] & ~pop;
      s2_go   = bypass | push;
      cnt_d   = cnt_q + 2'(push) - 2'(pop);
      in_ready  = in_ready_q;
      out_valid = vld_q[2] | (cnt_q != 2'd0);
      out_r     = (cnt_q != 2'd0) ? skid0_q : s2_q;
`else
      s2_go     = vld_q[2] & bus.out_ready_i;
      in_ready  = ~vld_q[1] | ~vld_q[2] | bus.out_ready_i;
      out_valid = vld_q[2];
      out_r     = s2_q;
`endif
      accept   = bus.in_valid_i & in_ready;
      s2_en    = vld_q[1] & (~vld_q[2] | s2_go);
      vld_d[1] = accept | (vld_q[1] & ~s2_en);
      vld_d[2] = s2_en  | (vld_q[2] & ~s2_go);
`ifdef FP_ADD_PRENORM_SKID_EN
      items_d  = 3'(vld_d[1]) + 3'(vld_d[2]) + 3'(cnt_d);
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q     <= '0;
         s1_l_q    <= '0;
         s1_s_q    <= '0;
         s1_exp_q  <= '0;
         s1_sign_q <= 1'b0;
         s1_sub_q  <= 1'b0;
         s2_q      <= '0;
      end else begin
         vld_q <= vld_d;
         if (accept) begin
            s1_l_q    <= sl;
            s1_s_q    <= s_al;
            s1_exp_q  <= el;
            s1_sign_q <= sign_l;
            s1_sub_q  <= bus.op_a_i[OPW-1] ^ bus.op_b_i[OPW-1];
         end
         if (s2_en) s2_q <= s2_d;
      end
   end

`ifdef FP_ADD_PRENORM_SKID_EN
   // in_ready_q promises room for one more even if the sink stalls from now on.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         skid0_q    <= '0;
         skid1_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         in_ready_q <= items_d < 3'd4;
         if (pop) skid0_q <= skid1_q;
         if (push) begin
            if (wr_hi) skid1_q <= s2_q;
            else       skid0_q <= s2_q;
         end
      end
   end
`endif

   assign bus.in_ready_o     = in_ready;
   assign bus.out_valid_o    = out_valid;
   assign bus.mant_prenorm_o = out_r.mant;
   assign bus.exp_prenorm_o  = out_r.exp;
   assign bus.sign_o         = out_r.sign;

endmodule

// File: tb/tb_fp_add_prenorm.sv
// Bench for fp_add_prenorm: directed corner cases, stalled burst, random traffic,
// mid-flight reset; results scored against an exact-arithmetic reference.
module tb_fp_add_prenorm;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_add_prenorm_if bif ();

   fp_add_prenorm dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bif)
   );

   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   logic [22:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Exact sum of the two magnitudes, truncated to the output frame with the
   // discarded part ORed into bit 0. Result packed as {mant[14:0], exp[6:0], sign}.
   function automatic logic [22:0] ref_add(input logic [15:0] a, input logic [15:0] b);
      longint unsigned ta, tb, ma, mb, ml, ms, r, big, m;
      int ea, eb, el;
      logic sl, sub, sgn;
      ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
      eb = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
      ta = {53'd0, a[14:10] != 5'd0, a[9:0]};
      tb = {53'd0, b[14:10] != 5'd0, b[9:0]};
      ma = ta << (ea - 1);
      mb = tb << (eb - 1);
      if (ma >= mb) begin ml = ma; ms = mb; el = ea; sl = a[15]; end
      else          begin ml = mb; ms = ma; el = eb; sl = b[15]; end
      sub = a[15] ^ b[15];
      r   = sub ? (ml - ms) : (ml + ms);
      big = r << 3;
      m   = big >> (el - 1);
      if ((m << (el - 1)) != big) m = m | 64'd1;
      sgn = (sub && r == 0) ? 1'b0 : sl;
      return {15'(m), 7'(el), sgn};
   endfunction

   function automatic logic [15:0] rnd_b(input logic [15:0] a);
      logic [15:0] b;
      case ($urandom_range(0, 3))
         0:       b = 16'($urandom);
         1:       b = a ^ 16'h8000;
         2:       b = {1'($urandom), a[14:10] - 5'($urandom_range(0, 3)), 10'($urandom)};
         default: b = {1'($urandom), 5'd0, 10'($urandom)};
      endcase
      return b;
   endfunction

   // Scoreboard: outputs checked (including while stalled), then accepts recorded.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bif.out_valid_o) begin
            if (exp_q.size() == 0) chk("spurious_out", 32'(bif.out_valid_o), 32'd0);
            else begin
               chk("result", {9'd0, bif.mant_prenorm_o, bif.exp_prenorm_o, bif.sign_o},
                   {9'd0, exp_q[0]});
               if (bif.out_ready_i) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (bif.in_valid_i && bif.in_ready_o)
            exp_q.push_back(ref_add(bif.op_a_i, bif.op_b_i));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single pair into an empty pipe; checks 2-cycle latency and the known result.
   task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [14:0] em, input logic [6:0] ee, input logic es);
      bif.op_a_i = a; bif.op_b_i = b; bif.in_valid_i = 1'b1; bif.out_ready_i = 1'b1;
      #1;
      chk($sformatf("%s_rdy", tag), 32'(bif.in_ready_o), 32'd1);
      tick();
      bif.in_valid_i = 1'b0;
      chk($sformatf("%s_lat1", tag), 32'(bif.out_valid_o), 32'd0);
      tick();
      chk($sformatf("%s_vld", tag), 32'(bif.out_valid_o), 32'd1);
      chk($sformatf("%s_val", tag), {9'd0, bif.mant_prenorm_o, bif.exp_prenorm_o, bif.sign_o},
          {9'd0, em, ee, es});
      tick();
   endtask

   task automatic drain(input string tag);
      int k;
      bif.in_valid_i = 1'b0; bif.out_ready_i = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || bif.out_valid_o) && k < 100) begin
         tick();
         k++;
      end
      chk($sformatf("%s_drained", tag), 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int sent, n0, cyc, acc, saw_full;
      logic [15:0] pa[8], pb[8];

      bif.in_valid_i = 1'b0; bif.op_a_i = '0; bif.op_b_i = '0; bif.out_ready_i = 1'b1;
      #1;
      chk("rst_vld",  32'(bif.out_valid_o),    32'd0);
      chk("rst_mant", 32'(bif.mant_prenorm_o), 32'd0);
      chk("rst_exp",  32'(bif.exp_prenorm_o),  32'd0);
      chk("rst_sign", 32'(bif.sign_o),         32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rel_rdy", 32'(bif.in_ready_o),  32'd1);
      chk("rel_vld", 32'(bif.out_valid_o), 32'd0);

      directed("one_plus_one", 16'h3C00, 16'h3C00, 15'h4000, 7'd15, 1'b0);
      directed("one_minus_one", 16'h3C00, 16'hBC00, 15'h0000, 7'd15, 1'b0);
      directed("negzero_sum", 16'h8000, 16'h8000, 15'h0000, 7'd1, 1'b1);
      directed("mixed_zero", 16'h0000, 16'h8000, 15'h0000, 7'd1, 1'b0);
      directed("small_add", 16'h3C00, 16'h1400, 15'h2008, 7'd15, 1'b0);
      directed("small_swap", 16'h1400, 16'h3C00, 15'h2008, 7'd15, 1'b0);
      directed("denorm_sticky", 16'h3C00, 16'h0001, 15'h2001, 7'd15, 1'b0);
      directed("swap_sub", 16'hC000, 16'h3C00, 15'h1000, 7'd16, 1'b1);
      directed("far_sticky", 16'h7BFF, 16'h0001, 15'h3FF9, 7'd30, 1'b0);
      directed("exp_ones", 16'h7C00, 16'h7C00, 15'h4000, 7'd31, 1'b0);

      // Back-to-back burst with a 5-cycle sink stall in the middle.
      for (int i = 0; i < 8; i++) begin
         pa[i] = 16'($urandom);
         pb[i] = rnd_b(pa[i]);
      end
      n0 = n_out; sent = 0; cyc = 0; saw_full = 0;
      bif.in_valid_i = 1'b1; bif.op_a_i = pa[0]; bif.op_b_i = pb[0];
      while (sent < 8 && cyc < 60) begin
         bif.out_ready_i = !(cyc >= 3 && cyc < 8);
         #1;
         if (!bif.in_ready_o) saw_full = 1;
         acc = int'(bif.in_ready_o);
         tick();
         cyc++;
         if (acc != 0) begin
            sent++;
            if (sent < 8) begin bif.op_a_i = pa[sent]; bif.op_b_i = pb[sent]; end
            else bif.in_valid_i = 1'b0;
         end
      end
      chk("burst_sent", 32'(sent), 32'd8);
      drain("burst");
      chk("burst_count", 32'(n_out - n0), 32'd8);
      chk("burst_full",  32'(saw_full),    32'd1);

      // Random traffic with random valid/ready.
      n0 = n_out; sent = 0; cyc = 0;
      while (sent < 300 && cyc < 3000) begin
         bif.in_valid_i  = ($urandom_range(0, 3) != 0);
         bif.op_a_i      = 16'($urandom);
         bif.op_b_i      = rnd_b(bif.op_a_i);
         bif.out_ready_i = ($urandom_range(0, 9) < 7);
         #1;
         acc = int'(bif.in_valid_i && bif.in_ready_o);
         tick();
         cyc++;
         sent += acc;
      end
      chk("rand_sent", 32'(sent), 32'd300);
      drain("rand");
      chk("rand_count", 32'(n_out - n0), 32'd300);

      // Reset with two results in flight.
      bif.out_ready_i = 1'b0; bif.in_valid_i = 1'b1;
      bif.op_a_i = 16'h3C00; bif.op_b_i = 16'h4000;
      tick();
      bif.op_a_i = 16'h4400; bif.op_b_i = 16'hC000;
      tick();
      bif.in_valid_i = 1'b0;
      chk("inflight_vld", 32'(bif.out_valid_o), 32'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("midrst_vld",  32'(bif.out_valid_o),    32'd0);
      chk("midrst_mant", 32'(bif.mant_prenorm_o), 32'd0);
      chk("midrst_exp",  32'(bif.exp_prenorm_o),  32'd0);
      chk("midrst_sign", 32'(bif.sign_o),         32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      bif.out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stale", 32'(bif.out_valid_o), 32'd0);
      end
      directed("post_rst", 16'h3C00, 16'h3C00, 15'h4000, 7'd15, 1'b0);
      drain("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
